// File: rtl/pe_conv_controller.sv
// pe_conv_controller: per-channel kernel load, window stream and in-place BRAM accumulation sequencer
module pe_conv_controller #(
  parameter int IMG_W        = 128,
  parameter int IMG_H        = 128,
  parameter int ADDR_WIDTH   = 14,
  parameter int MULT_LATENCY = 2,
  parameter int CH_WIDTH     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CH_WIDTH-1:0]   num_in_ch,
  output logic                  busy,
  output logic                  done,
  input  logic                  kernel_valid,
  output logic                  kernel_ready,
  input  logic                  win_valid,
  output logic                  win_ready,
  output logic                  Rst_kernel,
  output logic                  Wr_kernel,
  output logic                  add_bias,
  output logic [ADDR_WIDTH-1:0] addra_output_BRAM,
  output logic [ADDR_WIDTH-1:0] addrb_output_BRAM,
  output logic                  ena_output_BRAM,
  output logic                  wea_output_BRAM,
  output logic                  enb_output_BRAM,
  output logic                  final_valid
);
  typedef enum logic [2:0] {IDLE, LOAD_K, STREAM, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  first;
    logic                  last;
  } ent_t;
  localparam int DW = $clog2(MULT_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(IMG_W * IMG_H - 1);
  localparam logic [DW-1:0] LAST_DRN = DW'(MULT_LATENCY - 1);
  state_t                state_q, state_d;
  logic [CH_WIDTH-1:0]   ch_q, ch_d, last_ch_q, last_ch_d;
  logic [ADDR_WIDTH-1:0] pix_q, pix_d, addr_q, addr_d;
  logic [DW-1:0]         drn_q, drn_d;
  logic                  v_q [MULT_LATENCY];
  ent_t                  e_q [MULT_LATENCY];
  logic                  accept, out_v;
  ent_t                  out_e;
  assign kernel_ready = state_q == LOAD_K;
  assign win_ready    = state_q == STREAM;
  assign busy         = state_q inside {LOAD_K, STREAM, DRAIN};
  assign Rst_kernel   = state_q inside {LOAD_K, STREAM, DRAIN};
  assign done         = state_q == DONE;
  assign Wr_kernel    = kernel_ready & kernel_valid;
  assign accept       = win_ready & win_valid;
  assign out_v        = v_q[MULT_LATENCY-1];
  assign out_e        = e_q[MULT_LATENCY-1];
  assign ena_output_BRAM   = out_v;
  assign wea_output_BRAM   = out_v;
  assign enb_output_BRAM   = out_v & ~out_e.first;
  assign add_bias          = out_v & out_e.first;
  assign final_valid       = out_v & out_e.last;
  assign addra_output_BRAM = addr_d;
  assign addrb_output_BRAM = addr_d;
  // next-state and counter updates; a channel ends only after the pipe has drained
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    last_ch_d = last_ch_q;
    pix_d     = pix_q;
    drn_d     = drn_q;
    addr_d    = out_v ? out_e.addr : addr_q;
    case (state_q)
      IDLE: if (start) begin
        last_ch_d = (num_in_ch == '0) ? '0 : num_in_ch - 1'b1;
        ch_d      = '0;
        state_d   = LOAD_K;
      end
      LOAD_K: if (kernel_valid) begin
        pix_d   = '0;
        state_d = STREAM;
      end
      STREAM: if (accept) begin
        pix_d = pix_q + 1'b1;
        drn_d = '0;
        state_d = (pix_q == LAST_PIX) ? DRAIN : STREAM;
      end
      DRAIN: if (drn_q == LAST_DRN) begin
        state_d = (ch_q == last_ch_q) ? DONE : LOAD_K;
        ch_d    = (ch_q == last_ch_q) ? ch_q : ch_q + 1'b1;
      end else drn_d = drn_q + 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // controller state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      last_ch_q <= '0;
      pix_q     <= '0;
      drn_q     <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      last_ch_q <= last_ch_d;
      pix_q     <= pix_d;
      drn_q     <= drn_d;
      addr_q    <= addr_d;
    end
  end
  // valid bits of the pipe that mirrors the multiplier latency; reset discards in-flight windows
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MULT_LATENCY; i++) v_q[i] <= 1'b0;
    end else begin
      v_q[0] <= accept;
      for (int i = 1; i < MULT_LATENCY; i++) v_q[i] <= v_q[i-1];
    end
  end
  // pixel tags travelling alongside the valid bits
  always_ff @(posedge clk) begin
    e_q[0] <= '{addr: pix_q, first: ch_q == '0, last: ch_q == last_ch_q};
    for (int i = 1; i < MULT_LATENCY; i++) e_q[i] <= e_q[i-1];
  end
endmodule
